// File: rtl/chacha_stream_ctrl.sv
// Multi-block ChaCha20 stream controller: loads key/nonce/counter over a config
// stream, then feeds plaintext blocks through an external core and drains ciphertext.
//   state | meaning
//   IDLE  | waiting for start
//   CFG   | accepting 12 config words (key x8, nonce x3, counter)
//   LOAD  | collecting one plaintext block
//   CORE  | one-cycle core launch
//   WAIT  | waiting for core_done
//   DRAIN | streaming the ciphertext block out
//   FIN   | done pulse, back to IDLE
module chacha_stream_ctrl #(
    parameter int WORD_W = 32,
    parameter int NB_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NB_W-1:0]   num_blocks,
    output logic              busy,
    output logic              done,
    output logic              error,
    input  logic [31:0]       cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              core_start,
    input  logic              core_done,
    output logic [255:0]      core_key,
    output logic [95:0]       core_nonce,
    output logic [31:0]       core_counter,
    output logic [511:0]      core_pt,
    input  logic [511:0]      core_ct
);

    localparam int WPB = 512 / WORD_W;
    localparam int PW  = $clog2(WPB);
    localparam logic [PW-1:0] LAST_W = PW'(WPB - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CFG   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_CORE  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    logic [2:0]      state;
    logic [NB_W-1:0] blk_left;
    logic [3:0]      cfg_idx;
    logic [PW-1:0]   wptr;
    logic [511:0]    ct_buf;

    // The drain buffer shifts down one word per transfer, so its low word is the
    // registered output and holds still while the sink stalls.
    assign out_data = ct_buf[WORD_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            blk_left     <= '0;
            cfg_idx      <= '0;
            wptr         <= '0;
            ct_buf       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            cfg_ready    <= 1'b0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            core_start   <= 1'b0;
            core_key     <= '0;
            core_nonce   <= '0;
            core_counter <= '0;
            core_pt      <= '0;
        end else begin
            done       <= 1'b0;
            core_start <= 1'b0;
            if (abort && state != S_IDLE) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                cfg_ready <= 1'b0;
                in_ready  <= 1'b0;
                out_valid <= 1'b0;
                cfg_idx   <= '0;
                wptr      <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            blk_left <= num_blocks;
                            error    <= 1'b0;
                            busy     <= 1'b1;
                            cfg_idx  <= '0;
                            wptr     <= '0;
                            if (num_blocks == '0) begin
                                state <= S_FIN;
                            end else begin
                                state     <= S_CFG;
                                cfg_ready <= 1'b1;
                            end
                        end
                    end
                    S_CFG: begin
                        if (cfg_valid) begin
                            case (cfg_idx)
                                4'd8:    core_nonce[31:0]  <= cfg_data;
                                4'd9:    core_nonce[63:32] <= cfg_data;
                                4'd10:   core_nonce[95:64] <= cfg_data;
                                4'd11:   core_counter      <= cfg_data;
                                default: core_key[int'(cfg_idx[2:0])*32 +: 32] <= cfg_data;
                            endcase
                            if (cfg_idx == 4'd11) begin
                                cfg_idx   <= '0;
                                cfg_ready <= 1'b0;
                                in_ready  <= 1'b1;
                                state     <= S_LOAD;
                            end else begin
                                cfg_idx <= cfg_idx + 4'd1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (in_valid) begin
                            core_pt[int'(wptr)*WORD_W +: WORD_W] <= in_data;
                            if (wptr == LAST_W) begin
                                wptr       <= '0;
                                in_ready   <= 1'b0;
                                core_start <= 1'b1;
                                state      <= S_CORE;
                            end else begin
                                wptr <= wptr + PW'(1);
                            end
                        end
                    end
                    S_CORE: state <= S_WAIT;
                    S_WAIT: begin
                        if (core_done) begin
                            ct_buf    <= core_ct;
                            out_valid <= 1'b1;
                            state     <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (out_ready) begin
                            ct_buf <= ct_buf >> WORD_W;
                            if (wptr == LAST_W) begin
                                wptr      <= '0;
                                out_valid <= 1'b0;
                                if (blk_left != NB_W'(1)) begin
                                    // A wrapped counter would reuse keystream, so stop instead.
                                    if (core_counter == 32'hFFFF_FFFF) begin
                                        error <= 1'b1;
                                        state <= S_FIN;
                                    end else begin
                                        core_counter <= core_counter + 32'd1;
                                        blk_left     <= blk_left - NB_W'(1);
                                        in_ready     <= 1'b1;
                                        state        <= S_LOAD;
                                    end
                                end else begin
                                    state <= S_FIN;
                                end
                            end else begin
                                wptr <= wptr + PW'(1);
                            end
                        end
                    end
                    S_FIN: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
